bypass_crossfader: RTL
======================

BYPASS_CROSSFADER -- requirements
Module: bypass_crossfader

Interface
REQ-001 SHALL have parameter DW, default 24: sample width, two's-complement signed.
REQ-002 SHALL have parameter RAMP_LOG2, default 8: crossfade length is 2^RAMP_LOG2 sample ticks.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sample_tick_i  input  1  one-cycle strobe, one per audio sample.
REQ-006 SHALL have port enable_i  input  1  effect on (1) / bypass (0), level-sensitive.
REQ-007 SHALL have port dry_i  input  DW  unprocessed sample, valid on sample_tick_i.
REQ-008 SHALL have port wet_i  input  DW  tremolo output sample, valid on sample_tick_i.
REQ-009 SHALL have port data_o  output  DW  crossfaded sample, registered.
REQ-010 SHALL have port fading_o  output  1  high while a ramp is in progress.

Function
REQ-011 SHALL hold gain g, unsigned, RAMP_LOG2+1 bits, range 0..2^RAMP_LOG2 (G_MAX).
REQ-012 SHALL implement states DRY (g=0), FADE_IN, WET (g=G_MAX), FADE_OUT; all updates only in cycles with sample_tick_i=1.
REQ-013 SHALL sample enable_i only on sample_tick_i; changes between ticks are ignored until next tick.
REQ-014 DRY: enable_i=1 -> FADE_IN, g+1 on same tick; else stay.
REQ-015 FADE_IN: g+1 per tick; when new g equals G_MAX -> WET; enable_i=0 -> FADE_OUT, g-1 from current value (no jump).
REQ-016 WET: enable_i=0 -> FADE_OUT, g-1 on same tick; else stay.
REQ-017 FADE_OUT: g-1 per tick; when new g equals 0 -> DRY; enable_i=1 -> FADE_IN, g+1 from current value.
REQ-018 g SHALL never wrap; it saturates at 0 and G_MAX.
REQ-019 SHALL compute acc = dry_i*(G_MAX-g) + wet_i*g with the updated g, signed, DW+RAMP_LOG2+2 bits, gain zero-extended before signed multiply.
REQ-020 data_o SHALL be acc arithmetically shifted right by RAMP_LOG2, truncated to DW bits (always in range: convex combination).
REQ-021 data_o SHALL update one clock after the tick that carries dry_i/wet_i (latency 1 cycle) and hold between ticks.
REQ-022 fading_o SHALL be registered, high in the same cycle data_o reflects a FADE_IN/FADE_OUT state, low in DRY/WET.
REQ-023 In DRY data_o SHALL equal dry_i exactly; in WET data_o SHALL equal wet_i exactly.

Reset
REQ-024 rst_n_i low SHALL immediately force state DRY, g=0, data_o=0, fading_o=0, independent of clk_i.
REQ-025 Reset mid-ramp SHALL abandon the ramp; after release the block starts in DRY and re-evaluates enable_i at the next tick.
REQ-026 Reset deassertion SHALL be taken synchronously to clk_i (no operation until the first rising edge after release).

Configuration
REQ-027 Macro BYPASS_CROSSFADER_ROUND_EN defined: SHALL add 2^(RAMP_LOG2-1) to acc before the shift (round half up); DRY/WET exactness of REQ-023 still holds.
REQ-028 Macro BYPASS_CROSSFADER_ROUND_EN undefined: SHALL use plain truncation per REQ-020, no rounding adder synthesized.

Verification (DW=24, RAMP_LOG2=8, tick every 4 clocks)
REQ-029 enable_i=0, dry_i=1000, wet_i=-1000, ticks -> data_o=1000, fading_o=0 one clock after each tick.
REQ-030 enable_i rises, held -> fading_o high for 255 ticks, at g=128 data_o=0, at tick 256 data_o=-1000, fading_o=0 (WET).
REQ-031 enable_i drops at g=100 -> next data_o uses g=99, monotonic return, DRY reached after 100 ticks total, data_o=1000.
REQ-032 sample_tick_i held low 50 clocks mid-ramp, inputs changing -> data_o, fading_o, g unchanged.
REQ-033 rst_n_i pulsed low at g=60 between clock edges -> data_o=0, fading_o=0 immediately; after release with enable_i=1, ramp restarts from g=1.
REQ-034 dry_i=0, wet_i=1, g=128 -> data_o=0 without macro, 1 with BYPASS_CROSSFADER_ROUND_EN; dry_i=wet_i=-8388608 any g -> -8388608.

Source files
------------

// File: rtl/bypass_crossfader.sv
// Gain-ramped dry/wet crossfader for effect bypass switching.
// Optional BYPASS_CROSSFADER_ROUND_EN: round half up before the output shift.
module bypass_crossfader #(
  parameter int DW        = 24,
  parameter int RAMP_LOG2 = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 sample_tick_i,
  input  logic                 enable_i,
  input  logic signed [DW-1:0] dry_i,
  input  logic signed [DW-1:0] wet_i,
  output logic signed [DW-1:0] data_o,
  output logic                 fading_o
);

  localparam int GW = RAMP_LOG2 + 1;
  localparam int AW = DW + RAMP_LOG2 + 2;
  localparam logic [GW-1:0] G_MAX = GW'(1) << RAMP_LOG2;
  localparam logic [GW-1:0] G_ZERO = '0;

  typedef enum logic [1:0] {
    DRY,
    FADE_IN,
    WET,
    FADE_OUT
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [GW-1:0]   g_q;
  logic [GW-1:0]   g_d;
  logic [GW-1:0]   g_up;
  logic [GW-1:0]   g_dn;
  state_t          st_up;
  state_t          st_dn;

  // Saturating step candidates; the FSM picks one direction per tick.
  assign g_up  = (g_q == G_MAX)  ? g_q : g_q + GW'(1);
  assign g_dn  = (g_q == G_ZERO) ? g_q : g_q - GW'(1);
  assign st_up = (g_up == G_MAX)  ? WET : FADE_IN;
  assign st_dn = (g_dn == G_ZERO) ? DRY : FADE_OUT;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    if (sample_tick_i) begin
      unique case (state_q)
        DRY: begin
          if (enable_i) begin
            g_d     = g_up;
            state_d = st_up;
          end
        end
        WET: begin
          if (!enable_i) begin
            g_d     = g_dn;
            state_d = st_dn;
          end
        end
        FADE_IN, FADE_OUT: begin
          if (enable_i) begin
            g_d     = g_up;
            state_d = st_up;
          end else begin
            g_d     = g_dn;
            state_d = st_dn;
          end
        end
        default: begin
          g_d     = G_ZERO;
          state_d = DRY;
        end
      endcase
    end
  end

  logic [GW-1:0]          g_inv;
  logic signed [AW-1:0]   dry_x;
  logic signed [AW-1:0]   wet_x;
  logic signed [AW-1:0]   gd_x;
  logic signed [AW-1:0]   gw_x;
  logic signed [AW-1:0]   prod;
  logic signed [AW-1:0]   acc;
  logic signed [DW-1:0]   data_d;

  assign g_inv = G_MAX - g_d;
  assign dry_x = AW'(dry_i);
  assign wet_x = AW'(wet_i);
  assign gd_x  = $signed(AW'(g_inv));
  assign gw_x  = $signed(AW'(g_d));
  assign prod  = dry_x * gd_x + wet_x * gw_x;

`ifdef BYPASS_CROSSFADER_ROUND_EN
  localparam logic signed [AW-1:0] RND = AW'(1) <<< (RAMP_LOG2 - 1);
  assign acc = prod + RND;
`else
  assign acc = prod;
`endif

  assign data_d = DW'(acc >>> RAMP_LOG2);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= DRY;
      g_q      <= '0;
      data_o   <= '0;
      fading_o <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      if (sample_tick_i) begin
        data_o   <= data_d;
        fading_o <= (state_d == FADE_IN) || (state_d == FADE_OUT);
      end
    end
  end

endmodule
